// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M/RV64M multiply/divide unit for the EX stage.
//
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per cycle.
// Multiplies use a shift-add product. Divides use restoring division.
// Both work on operand magnitudes; a final FIXUP cycle applies the sign.
// Divide-by-zero and signed overflow skip the iterations.
// Their results appear one edge after accept.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             drop any in-flight op, return to IDLE next edge
//   in_valid/in_ready op handshake (in_ready high only in IDLE)
//   funct3            M-extension op select (000 MUL .. 111 REMU)
//   op_a, op_b        rs1 / rs2 values
//   in_tag            destination tag carried through with the op
//   out_valid/ready   result handshake; result/out_tag held until taken
//   result, out_tag   operation result and the tag of the producing op
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ONE_W    = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);

  // Two's-complement negate when en is set (single-width).
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
    if (en) begin
      cond_neg = ~v + ONE;
    end else begin
      cond_neg = v;
    end
  endfunction

  // Two's-complement negate when en is set (double-width product).
  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic en);
    if (en) begin
      cond_neg_w = ~v + ONE_W;
    end else begin
      cond_neg_w = v;
    end
  endfunction

  logic [1:0]        state_q, state_d, state_nxt;
  logic [2:0]        f3_q, f3_d;
  logic [TAG_W-1:0]  tag_q, tag_d, out_tag_q, out_tag_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d, result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d, spec_q, spec_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic              accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, spec_val;
  logic [XLEN:0]     mul_sum, rem_sh, rem_trial;
  logic [2*XLEN-1:0] mul_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  // Decode the presented op: signedness, magnitudes and special-case results.
  always_comb begin
    accept   = in_valid & in_ready_q & ~flush;
    is_div   = funct3[2];
    a_signed = (funct3 == F_MULH) | (funct3 == F_MULHSU) | (funct3 == F_DIV) | (funct3 == F_REM);
    b_signed = (funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_mag    = cond_neg(op_a, a_neg);
    b_mag    = cond_neg(op_b, b_neg);
    div_zero = is_div & (op_b == ZERO);
    // a_signed among divide ops means DIV/REM
    div_ovf  = is_div & a_signed & (op_a == MIN_INT) & (op_b == ALL_ONES);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) begin
      spec_val = funct3[1] ? op_a : ALL_ONES;
    end else if (div_ovf) begin
      spec_val = funct3[1] ? ZERO : MIN_INT;
    end else begin
      spec_val = ZERO;
    end
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    // the upper half accumulates the multiplicand with a carry bit
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
    if (prod_q[0]) begin
      mul_step = {mul_sum, prod_q[XLEN-1:1]};
    end else begin
      mul_step = {1'b0, prod_q[2*XLEN-1:1]};
    end
    // shift the next dividend bit into the remainder, then trial-subtract
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    rem_trial = rem_sh - {1'b0, b_q};
  end

  // Apply result signs and select the output field for the finished op.
  always_comb begin
    prod_fix = cond_neg_w(prod_q, qneg_q);
    quo_fix  = cond_neg(quo_q, qneg_q);
    rem_fix  = cond_neg(rem_q, rneg_q);
    fix_val  = ZERO;
    if (spec_q) begin
      fix_val = spec_val_q;
    end else begin
      case (f3_q)
        F_MUL:                     fix_val = prod_fix[XLEN-1:0];
        F_MULH, F_MULHSU, F_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
        F_DIV, F_DIVU:             fix_val = quo_fix;
        F_REM, F_REMU:             fix_val = rem_fix;
        default:                   fix_val = ZERO;
      endcase
    end
  end

  // FSM sequencing and next values for all registers.
  always_comb begin
    state_nxt  = state_q;
    f3_d       = f3_q;
    tag_d      = tag_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    out_tag_d  = out_tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d       = funct3;
          tag_d      = in_tag;
          a_d        = a_mag;
          b_d        = b_mag;
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          cnt_d      = CNT_ZERO;
          spec_val_d = spec_val;
          if (is_div) begin
            rem_d = ZERO;
            quo_d = a_mag;
          end else begin
            prod_d = {ZERO, b_mag};
          end
          // Special cases go through FIXUP only to pick their fixed result.
          if (div_zero | div_ovf) begin
            spec_d    = 1'b1;
            state_nxt = S_FIXUP;
          end else begin
            spec_d    = 1'b0;
            state_nxt = S_BUSY;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_ONE;
        if (f3_q[2]) begin
          if (rem_trial[XLEN]) begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end else begin
            rem_d = rem_trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end
        end else begin
          prod_d = mul_step;
        end
        if (cnt_q == CNT_LAST) begin
          state_nxt = S_FIXUP;
        end else begin
          state_nxt = S_BUSY;
        end
      end
      S_FIXUP: begin
        result_d  = fix_val;
        out_tag_d = tag_q;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_nxt;
    end
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      f3_q        <= 3'd0;
      tag_q       <= {TAG_W{1'b0}};
      a_q         <= ZERO;
      b_q         <= ZERO;
      prod_q      <= {2*XLEN{1'b0}};
      quo_q       <= ZERO;
      rem_q       <= ZERO;
      cnt_q       <= CNT_ZERO;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_val_q  <= ZERO;
      result_q    <= ZERO;
      out_tag_q   <= {TAG_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      tag_q       <= tag_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      spec_q      <= spec_d;
      spec_val_q  <= spec_val_d;
      result_q    <= result_d;
      out_tag_q   <= out_tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit.
// It instantiates one 32-bit unit and one 64-bit unit.
// A behavioural model computes each expected result with wide signed/unsigned
// arithmetic, plus the expected latency.
// A negedge monitor compares every valid output cycle against a scoreboard.
// Directed vectors carry hand-computed results that pin the model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, out_ready;
  logic [2:0]  funct3;
  logic [63:0] op_a, op_b;
  logic [4:0]  in_tag;
  logic        iv32, ir32, ov32, iv64, ir64, ov64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  tag32, tag64;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv32), .in_ready(ir32),
    .funct3(funct3), .op_a(op_a[31:0]), .op_b(op_b[31:0]), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .result(res32), .out_tag(tag32));

  muldiv_unit #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv64), .in_ready(ir64),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .result(res64), .out_tag(tag64));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  int last_acc = 0;
  int tag_n    = 1;

  typedef struct {
    int          unit;
    logic [63:0] res;
    logic [4:0]  tag;
    int          acc;
    int          lat;
    bit          seen;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference result from plain wide arithmetic (SV division truncates toward zero).
  function automatic logic [63:0] model(input int xl, input logic [2:0] f3,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [129:0] av, bv, mask, r;
    logic signed [129:0] sav, sbv;
    bit sa, sb_s;
    mask = (130'd1 << xl) - 130'd1;
    av   = {66'd0, a} & mask;
    bv   = {66'd0, b} & mask;
    sa   = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    sb_s = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    if (sa && av[xl-1]) av = av - (130'd1 << xl);
    if (sb_s && bv[xl-1]) bv = bv - (130'd1 << xl);
    sav = $signed(av);
    sbv = $signed(bv);
    case (f3)
      3'd0:             r = av * bv;
      3'd1, 3'd2, 3'd3: r = (av * bv) >> xl;
      3'd4, 3'd5:       r = (bv == 130'd0) ? mask : ((f3 == 3'd4) ? 130'(sav / sbv) : av / bv);
      default:          r = (bv == 130'd0) ? av   : ((f3 == 3'd6) ? 130'(sav % sbv) : av % bv);
    endcase
    return 64'(r & mask);
  endfunction

  // Expected accept-to-out_valid edges: 1 for special divides, else XLEN+1.
  function automatic int mlat(input int xl, input logic [2:0] f3,
                              input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, am, bm;
    m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am = a & m;
    bm = b & m;
    if (f3[2] && bm == 64'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && bm == m && am == ((m >> 1) + 64'd1)) return 1;
    return xl + 1;
  endfunction

  task automatic push(input int u);
    exp_t e;
    int xl;
    xl     = (u == 0) ? 32 : 64;
    e.unit = u;
    e.res  = model(xl, funct3, op_a, op_b);
    e.tag  = in_tag;
    e.acc  = cyc + 1;
    e.lat  = mlat(xl, funct3, op_a, op_b);
    e.seen = 1'b0;
    sb.push_back(e);
    last_acc = e.acc;
  endtask

  task automatic check_unit(input int u, input logic ov, input logic [63:0] res,
                            input logic [4:0] tg, input logic ir);
    if (ov === 1'b1) begin
      if (sb.size() == 0 || sb[0].unit != u) begin
        n_checks++;
        n_err++;
        $display("FAIL spurious_out_u%0d: out_valid=1 result=0x%0h, expected no result", u, res);
      end else begin
        chk($sformatf("result_u%0d", u), res, sb[0].res);
        chk($sformatf("out_tag_u%0d", u), 64'(tg), 64'(sb[0].tag));
        chk($sformatf("in_ready_in_done_u%0d", u), 64'(ir), 64'd0);
        if (!sb[0].seen) begin
          chk($sformatf("latency_u%0d", u), 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          sb[0].seen = 1'b1;
        end
        if (out_ready === 1'b1) begin
          hs_cyc = cyc + 1;
          void'(sb.pop_front());
        end
      end
    end
  endtask

  // Compare process: sample away from the active edge, track accepts/handshakes.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check_unit(0, ov32, {32'd0, res32}, tag32, ir32);
      check_unit(1, ov64, res64, tag64, ir64);
      if (iv32 && ir32 && !flush) push(0);
      if (iv64 && ir64 && !flush) push(1);
      if (flush) sb.delete();
    end else begin
      sb.delete();
    end
  end

  task automatic present(input int u, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    in_tag = 5'(tag_n);
    tag_n++;
    if (u == 0) iv32 = 1'b1;
    else iv64 = 1'b1;
  endtask

  task automatic wait_accept(input int u);
    bit got;
    logic rdy;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      rdy = (u == 0) ? ir32 : ir64;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) got = 1'b1;
    end
    iv32 = 1'b0;
    iv64 = 1'b0;
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input int u, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] hand, input string nm);
    chk({"model_", nm}, model((u == 0) ? 32 : 64, f3, a, b), hand);
    present(u, f3, a, b);
    wait_accept(u);
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_ov;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; iv32 = 1'b0; iv64 = 1'b0;
    funct3 = 3'd0; op_a = 64'd0; op_b = 64'd0; in_tag = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready32", 64'(ir32), 64'd1);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    chk("rst_result32", {32'd0, res32}, 64'd0);
    chk("rst_out_tag32", 64'(tag32), 64'd0);
    chk("rst_in_ready64", 64'(ir64), 64'd1);
    chk("rst_result64", res64, 64'd0);

    // 32-bit directed vectors
    do_op(0, 3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, "mul");
    do_op(0, 3'd1, 64'h80000000, 64'h80000000, 64'h40000000, "mulh");
    do_op(0, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, "mulhu");
    do_op(0, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, "mulhsu");
    do_op(0, 3'd1, 64'hFFFFFFFE, 64'h3,        64'hFFFFFFFF, "mulh_neg");
    do_op(0, 3'd3, 64'h80000000, 64'h2,        64'h1,        "mulhu_carry");
    do_op(0, 3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, "div");
    do_op(0, 3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, "rem");
    do_op(0, 3'd4, 64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, "div_negb");
    do_op(0, 3'd6, 64'h7,        64'hFFFFFFFE, 64'h1,        "rem_negb");
    do_op(0, 3'd5, 64'd100,      64'd7,        64'd14,       "divu");
    do_op(0, 3'd7, 64'd100,      64'd7,        64'd2,        "remu");
    do_op(0, 3'd5, 64'd3,        64'd10,       64'd0,        "divu_small");
    do_op(0, 3'd5, 64'hFFFFFFFF, 64'hFFFFFFFE, 64'h1,        "divu_top");
    do_op(0, 3'd7, 64'hFFFFFFFF, 64'hFFFFFFFE, 64'h1,        "remu_top");
    do_op(0, 3'd5, 64'd5,        64'd0,        64'hFFFFFFFF, "divu_by0");
    do_op(0, 3'd6, 64'd5,        64'd0,        64'd5,        "rem_by0");
    do_op(0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, "div_ovf");
    do_op(0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        "rem_ovf");

    // 64-bit directed vectors
    do_op(1, 3'd0, 64'h7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, "mul64");
    do_op(1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, "mulhu64");
    do_op(1, 3'd4, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, "div64");
    do_op(1, 3'd6, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFF, "rem64");
    do_op(1, 3'd5, 64'd100, 64'd7, 64'd14, "divu64");
    do_op(1, 3'd7, 64'd100, 64'd7, 64'd2,  "remu64");
    do_op(1, 3'd5, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, "divu64_by0");
    do_op(1, 3'd4, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, "div64_ovf");

    // Backpressure: DONE held 10 cycles, then back-to-back accept
    out_ready = 1'b0;
    present(0, 3'd0, 64'd6, 64'd7);
    wait_accept(0);
    seen_ov = 1'b0;
    for (int i = 0; i < 100 && !seen_ov; i++) begin
      @(posedge clk);
      #1;
      if (ov32 === 1'b1) seen_ov = 1'b1;
    end
    chk("bp_out_valid_seen", 64'(seen_ov), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_result_held", {32'd0, res32}, 64'd42);
    present(0, 3'd5, 64'd50, 64'd5);
    out_ready = 1'b1;
    wait_accept(0);
    chk("b2b_accept_cycle", 64'(last_acc), 64'(hs_cyc + 1));
    wait_drain();

    // Flush in the middle of a DIV
    present(0, 3'd4, 64'd1000, 64'd3);
    wait_accept(0);
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 64'(ir32), 64'd1);
    chk("flush_out_valid", 64'(ov32), 64'd0);
    repeat (50) @(posedge clk);
    #1;
    do_op(0, 3'd0, 64'd3, 64'd4, 64'd12, "mul_after_flush");

    // Reset in the middle of a 64-bit MULHU
    present(1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    wait_accept(1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_out_valid64", 64'(ov64), 64'd0);
    chk("midrst_result64", res64, 64'd0);
    chk("midrst_in_ready64", 64'(ir64), 64'd1);
    chk("midrst_out_tag64", 64'(tag64), 64'd0);
    do_op(1, 3'd0, 64'd3, 64'd4, 64'd12, "mul64_after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide unit for the pipelined core's EX stage. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles using one-bit-per-cycle shift-add and restoring-division datapaths. It is parametrised in operand width, and uses valid/ready handshakes on both input and output so the pipeline can stall on it. A flush input discards an in-flight op on branch mispredict or trap.

Parameters:
XLEN, 32, operand/result width (32 or 64)
TAG_W, 5, width of destination-register tag carried with each op

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  abort any in-flight or pending op; synchronous
in_valid  input  1  op presented
in_ready  output  1  unit can accept an op (high only in IDLE)
funct3  input  3  RISC-V M-extension funct3 (000 MUL … 111 REMU)
op_a  input  XLEN  rs1 value
op_b  input  XLEN  rs2 value
in_tag  input  TAG_W  rd index, returned with the result
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  XLEN  operation result
out_tag  output  TAG_W  tag of the op that produced result

Behaviour:
- FSM states: IDLE, BUSY, FIXUP, DONE.
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, out_tag=0, iteration counter=0.
- IDLE: in_ready=1. An op is accepted on an edge where in_valid&in_ready are both high; that edge is E0.
- At accept, latch funct3 and tag, the operand magnitudes (absolute value when the operand is signed for that op), and the result-sign flags.
- Signedness:
  - MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Special cases are detected at accept and go straight to DONE (out_valid high after E1):
  - Divide by zero (b==0): DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM with a=MIN_INT, b=-1): DIV gives MIN_INT; REM gives 0.
- Normal path:
  - BUSY runs exactly XLEN iterations on edges E1..E_XLEN.
  - Multiply uses a 2*XLEN-bit shift-add product.
  - Divide uses restoring division with an XLEN+1-bit partial remainder.
  - FIXUP is one edge (E_XLEN+1). It negates the product, quotient or remainder as required and selects the output:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign(a).
  - DONE: out_valid=1 after E_XLEN+1, so latency is XLEN+1 edges from accept.
- DONE holds result and out_tag stable until out_valid&out_ready. On that edge the unit returns to IDLE, and in_ready rises in the following cycle (no same-cycle re-accept).
- Backpressure: DONE may last any number of cycles; outputs must not change while out_ready is low.
- flush: from any state, go to IDLE on the next edge and drop out_valid; no result for the flushed op is ever produced. flush outranks in_valid, so no accept occurs on a flush edge.
- reset asserted mid-operation behaves as flush plus clearing result and out_tag to 0.
- funct3 is always a valid M op; no illegal-op handling.
- All arithmetic is modulo 2^XLEN on the output. No X propagation: unused datapath registers are held at their last value.

Test Plan:
1. MUL, a=7, b=0xFFFFFFFD (-3), out_ready=1 -> out_valid exactly 33 edges after accept, result=0xFFFFFFEB, out_tag echoes in_tag.
2. MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed division: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF. Unsigned division: DIVU 100/7 -> 14, REMU 100/7 -> 2.
4. Special cases, each with out_valid 1 edge after accept:
   - DIVU 5/0 -> 0xFFFFFFFF.
   - REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000/0xFFFFFFFF -> 0.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0 throughout. Then raise out_ready -> IDLE next edge, and a back-to-back second op is accepted one cycle later.
6. Flush and reset mid-operation:
   - flush at iteration 15 of a DIV -> IDLE next edge, no out_valid ever for that op; a following MUL 3*4 -> 12.
   - reset mid-BUSY -> out_valid=0, result=0, in_ready=1.
   - Repeat cases 1 and 3 with XLEN=64, e.g. MULHU 0xFFFF…FF squared -> 0xFFFF…FE.
